// File: rtl/hbridge_pwm_driver.sv
// hbridge_pwm_driver: turns the 3-bit {brake, dir, en} bridge command and a
// duty word into four full-bridge gate drives, with PWM, soft-start/stop duty
// ramping, forced ramp-down on reversal and dead time on configuration change.
// Optional driver-fault latch is enabled by defining HBRIDGE_FAULT_EN.
module hbridge_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 50,
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_STEP   = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [2:0]          cmd_i,
    input  logic [PWM_BITS-1:0] duty_i,
`ifdef HBRIDGE_FAULT_EN
    input  logic                fault_n_i,
    output logic                fault_o,
`endif
    output logic                gate_hs_a,
    output logic                gate_ls_a,
    output logic                gate_hs_b,
    output logic                gate_ls_b,
    output logic                pwm_sync_o,
    output logic                busy_o,
    output logic [PWM_BITS-1:0] duty_cur_o
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST  = '1;
    localparam logic [PWM_BITS:0]   STEP      = (PWM_BITS+1)'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE_FWD,
        S_DRIVE_REV,
        S_BRAKE,
        S_DEAD
    } state_t;

    // Gate vector order is {hs_a, ls_a, hs_b, ls_b}.
    function automatic logic [3:0] gates_for(input state_t st, input logic raw);
        case (st)
            S_DRIVE_FWD: gates_for = {raw, 1'b0, 1'b0, 1'b1};
            S_DRIVE_REV: gates_for = {1'b0, 1'b1, raw, 1'b0};
            S_BRAKE:     gates_for = 4'b0101;
            default:     gates_for = 4'b0000;
        endcase
    endfunction

    // Move cur toward tgt by at most RAMP_STEP, never overshooting.
    function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        logic [PWM_BITS:0] diff;
        ramp_toward = cur;
        if (tgt > cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            ramp_toward = (diff > STEP) ? PWM_BITS'({1'b0, cur} + STEP) : tgt;
        end else if (cur > tgt) begin
            diff = {1'b0, cur} - {1'b0, tgt};
            ramp_toward = (diff > STEP) ? PWM_BITS'({1'b0, cur} - STEP) : tgt;
        end
    endfunction

    logic [2:0]          cmd_q;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                sync_q;
    state_t              state_q;
    logic [DEAD_W-1:0]   dead_q;
    logic [PWM_BITS-1:0] duty_cur_q;
    logic [3:0]          gates_q;
    logic                busy_q;

    logic en_w, dir_w, brake_w;
    logic tick, period_start, pwm_raw;
    logic fault_trip, fault_hold;

    assign en_w    = cmd_q[0];
    assign dir_w   = cmd_q[1];
    assign brake_w = cmd_q[2];

    assign tick         = (pre_q == PRE_LAST);
    assign period_start = tick && (cnt_q == CNT_LAST);
    assign pre_d        = tick ? '0 : pre_q + 1'b1;
    assign cnt_d        = tick ? cnt_q + 1'b1 : cnt_q;
    assign pwm_raw      = (cnt_q < duty_cur_q);

`ifdef HBRIDGE_FAULT_EN
    logic fault_n_q, fault_q;

    // Register the fault pin once and latch a fault until en drops with the pin healthy.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            fault_n_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            fault_n_q <= fault_n_i;
            if (!fault_n_q) begin
                fault_q <= 1'b1;
            end else if (!en_w) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign fault_trip = !fault_n_q;
    assign fault_hold = fault_q | !fault_n_q;
    assign fault_o    = fault_q;
`else
    assign fault_trip = 1'b0;
    assign fault_hold = 1'b0;
`endif

    // Command register plus prescaler, PWM counter and period-start pulse.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cmd_q  <= '0;
            pre_q  <= '0;
            cnt_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            cmd_q  <= cmd_i;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            sync_q <= period_start;
        end
    end

    // Bridge FSM: gates are registered together with the state they belong to.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q    <= S_IDLE;
            dead_q     <= '0;
            duty_cur_q <= '0;
            gates_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    duty_cur_q <= '0;
                    busy_q     <= 1'b0;
                    gates_q    <= '0;
                    if (en_w && !brake_w && !fault_hold) begin
                        state_q <= dir_w ? S_DRIVE_REV : S_DRIVE_FWD;
                        gates_q <= gates_for(dir_w ? S_DRIVE_REV : S_DRIVE_FWD, pwm_raw);
                    end
                end

                S_DRIVE_FWD, S_DRIVE_REV: begin
                    if (brake_w || !en_w || fault_trip) begin
                        state_q    <= S_DEAD;
                        dead_q     <= '0;
                        duty_cur_q <= '0;
                        gates_q    <= '0;
                        busy_q     <= 1'b1;
                    end else if (dir_w != (state_q == S_DRIVE_REV)) begin
                        // Reversal: ramp to zero first, then swap legs through dead time.
                        if (period_start && (duty_cur_q == '0)) begin
                            state_q <= S_DEAD;
                            dead_q  <= '0;
                            gates_q <= '0;
                        end else begin
                            if (period_start) begin
                                duty_cur_q <= ramp_toward(duty_cur_q, '0);
                            end
                            gates_q <= gates_for(state_q, pwm_raw);
                        end
                        busy_q <= 1'b1;
                    end else begin
                        if (period_start) begin
                            duty_cur_q <= ramp_toward(duty_cur_q, duty_i);
                        end
                        gates_q <= gates_for(state_q, pwm_raw);
                        busy_q  <= 1'b0;
                    end
                end

                S_BRAKE: begin
                    duty_cur_q <= '0;
                    busy_q     <= 1'b0;
                    gates_q    <= gates_for(S_BRAKE, 1'b0);
                    if (!brake_w || fault_trip) begin
                        state_q <= S_DEAD;
                        dead_q  <= '0;
                        gates_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_DEAD: begin
                    duty_cur_q <= '0;
                    gates_q    <= '0;
                    busy_q     <= 1'b1;
                    if (dead_q == DEAD_LAST) begin
                        // Destination chosen at exit: brake > !en > dir.
                        busy_q <= 1'b0;
                        if (fault_hold) begin
                            state_q <= S_IDLE;
                        end else if (brake_w) begin
                            state_q <= S_BRAKE;
                            gates_q <= gates_for(S_BRAKE, 1'b0);
                        end else if (!en_w) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= dir_w ? S_DRIVE_REV : S_DRIVE_FWD;
                            gates_q <= gates_for(dir_w ? S_DRIVE_REV : S_DRIVE_FWD, pwm_raw);
                        end
                    end else begin
                        dead_q <= dead_q + 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    duty_cur_q <= '0;
                    gates_q    <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign gate_hs_a  = gates_q[3];
    assign gate_ls_a  = gates_q[2];
    assign gate_hs_b  = gates_q[1];
    assign gate_ls_b  = gates_q[0];
    assign pwm_sync_o = sync_q;
    assign busy_o     = busy_q;
    assign duty_cur_o = duty_cur_q;

endmodule
